// File: rtl/mem_arb_pkg.sv
// Shared types for the instruction/data memory port arbiter.
// Holds the FSM state encoding, the latched request record and a word-align helper.
package mem_arb_pkg;

    typedef enum logic [1:0] {
        ARB_IDLE,
        ARB_SERVE_I,
        ARB_SERVE_D
    } arb_state_t;

    typedef struct packed {
        logic [31:0] addr;
        logic [3:0]  rmask;
        logic [3:0]  wmask;
        logic [31:0] wdata;
    } mem_req_t;

    function automatic logic [31:0] align_word(input logic [31:0] a);
        return {a[31:2], 2'b00};
    endfunction

endpackage

// File: rtl/arb_burst_ctr.sv
// Saturating count of consecutive data grants made while a fetch was waiting.
module arb_burst_ctr #(
    parameter int MAX   = 4,
    parameter int CNT_W = $clog2(MAX + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             inc,
    output logic [CNT_W-1:0] cnt
);

    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (inc && (cnt != CNT_MAX)) begin
            cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one memory port between fetch and data requesters; data has priority,
// bounded by a burst limit so a waiting fetch is always served eventually.
//
// state        | meaning
// ARB_IDLE     | no grant; arbitrate on the next edge, request register is 0
// ARB_SERVE_I  | fetch request latched and driven on mem_*, waiting for mem_resp
// ARB_SERVE_D  | data request latched and driven on mem_*, waiting for mem_resp
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int MAX_D_BURST = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] imem_addr,
    input  logic [3:0]  imem_rmask,
    output logic [31:0] imem_rdata,
    output logic        imem_resp,
    input  logic [31:0] dmem_addr,
    input  logic [3:0]  dmem_rmask,
    input  logic [3:0]  dmem_wmask,
    input  logic [31:0] dmem_wdata,
    output logic [31:0] dmem_rdata,
    output logic        dmem_resp,
    output logic [31:0] mem_addr,
    output logic [3:0]  mem_rmask,
    output logic [3:0]  mem_wmask,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata,
    input  logic        mem_resp
);

    localparam int CNT_W = $clog2(MAX_D_BURST + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_D_BURST);

    arb_state_t       state, state_nxt;
    mem_req_t         req, req_nxt;
    logic [CNT_W-1:0] d_cnt;
    logic             cnt_clr, cnt_inc;
    logic             i_req, d_req, d_capped;

    assign i_req    = |imem_rmask;
    assign d_req    = (|dmem_rmask) | (|dmem_wmask);
    assign d_capped = (d_cnt == CNT_MAX);

    arb_burst_ctr #(.MAX(MAX_D_BURST), .CNT_W(CNT_W)) u_burst_ctr (
        .clk (clk),
        .rst (rst),
        .clr (cnt_clr),
        .inc (cnt_inc),
        .cnt (d_cnt)
    );

    always_comb begin
        state_nxt = state;
        req_nxt   = req;
        cnt_clr   = 1'b0;
        cnt_inc   = 1'b0;
        case (state)
            ARB_IDLE: begin
                if (d_req && !(i_req && d_capped)) begin
                    state_nxt = ARB_SERVE_D;
                    req_nxt   = '{addr: align_word(dmem_addr), rmask: dmem_rmask,
                                  wmask: dmem_wmask, wdata: dmem_wdata};
                    // The streak only grows while a fetch is actually being held off.
                    cnt_inc   = i_req;
                    cnt_clr   = !i_req;
                end else if (i_req) begin
                    state_nxt = ARB_SERVE_I;
                    req_nxt   = '{addr: align_word(imem_addr), rmask: imem_rmask,
                                  wmask: 4'h0, wdata: 32'h0};
                    cnt_clr   = 1'b1;
                end else begin
                    cnt_clr   = 1'b1;
                end
            end
            ARB_SERVE_I, ARB_SERVE_D: begin
                if (mem_resp) begin
                    state_nxt = ARB_IDLE;
                    req_nxt   = '0;
                end
            end
            default: begin
                state_nxt = ARB_IDLE;
                req_nxt   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= ARB_IDLE;
            req   <= '0;
        end else begin
            state <= state_nxt;
            req   <= req_nxt;
        end
    end

    assign mem_addr  = req.addr;
    assign mem_rmask = req.rmask;
    assign mem_wmask = req.wmask;
    assign mem_wdata = req.wdata;

    // Responses pass straight through in the completion cycle; rdata is zeroed otherwise.
    assign imem_resp  = (state == ARB_SERVE_I) && mem_resp;
    assign dmem_resp  = (state == ARB_SERVE_D) && mem_resp;
    assign imem_rdata = imem_resp ? mem_rdata : 32'h0;
    assign dmem_rdata = dmem_resp ? mem_rdata : 32'h0;

endmodule
